// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I multicycle controller: opcodes, FSM states,
// ALU select codes and datapath mux selects.
package riscv_pkg;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecuteR,
    StExecuteI,
    StJal,
    StBeq,
    StAluWb
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } alu_op_e;

  localparam logic [1:0] RESULT_ALUOUT = 2'b00;
  localparam logic [1:0] RESULT_DATA   = 2'b01;
  localparam logic [1:0] RESULT_ALU    = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RD1   = 2'b10;

  localparam logic [1:0] SRC_B_RD2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/riscv_alu_decoder.sv
// ALU decoder: maps the controller's alu_op plus instruction fields onto the
// ALU select code.
module riscv_alu_decoder
  import riscv_pkg::*;
(
  input  alu_op_e     alu_op_i,
  input  logic [2:0]  funct3_i,
  input  logic        op5_i,
  input  logic        funct7b5_i,
  output logic [2:0]  alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    unique case (alu_op_i)
      AluOpAdd: alu_control_o = ALU_ADD;
      AluOpSub: alu_control_o = ALU_SUB;
      AluOpFunct: begin
        unique case (funct3_i)
          // op[5] separates R-type sub from I-type addi, which has no sub form
          3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multicycle RV32I control unit: state register plus combinational output decode.
// Define RISCV_CTRL_BNE_EN to make funct3=001 branch on ~zero (bne support).
module riscv_mc_controller
  import riscv_pkg::*;
#(
  parameter int unsigned ALU_SEL_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           imm_src,
  output logic [ALU_SEL_W-1:0] alu_control
);

  state_e     state_q;
  alu_op_e    alu_op;
  logic       pc_update;
  logic       branch;
  logic       branch_cond;
  logic [2:0] alu_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      unique case (state_q)
        StFetch: state_q <= StDecode;
        StDecode: begin
          unique case (op)
            OP_LW, OP_SW: state_q <= StMemAdr;
            OP_RTYPE:     state_q <= StExecuteR;
            OP_ITYPE:     state_q <= StExecuteI;
            OP_JAL:       state_q <= StJal;
            OP_BEQ:       state_q <= StBeq;
            default:      state_q <= StFetch;
          endcase
        end
        StMemAdr:   state_q <= (op == OP_LW) ? StMemRead : StMemWrite;
        StMemRead:  state_q <= StMemWb;
        StMemWb:    state_q <= StFetch;
        StMemWrite: state_q <= StFetch;
        StExecuteR: state_q <= StAluWb;
        StExecuteI: state_q <= StAluWb;
        StJal:      state_q <= StAluWb;
        StAluWb:    state_q <= StFetch;
        StBeq:      state_q <= StFetch;
        default:    state_q <= StFetch;
      endcase
    end
  end

  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RESULT_ALUOUT;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RD2;
    alu_op     = AluOpAdd;
    unique case (state_q)
      StFetch: begin
        ir_write   = 1'b1;
        alu_src_b  = SRC_B_FOUR;
        result_src = RESULT_ALU;
        pc_update  = 1'b1;
      end
      // Branch target is computed here so BEQ can compare in the same pass.
      StDecode: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
      end
      StMemAdr: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_IMM;
      end
      StMemRead: adr_src = 1'b1;
      StMemWb: begin
        result_src = RESULT_DATA;
        reg_write  = 1'b1;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      StExecuteR: begin
        alu_src_a = SRC_A_RD1;
        alu_op    = AluOpFunct;
      end
      StExecuteI: begin
        alu_src_a = SRC_A_RD1;
        alu_src_b = SRC_B_IMM;
        alu_op    = AluOpFunct;
      end
      StAluWb: reg_write = 1'b1;
      StJal: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_FOUR;
        pc_update = 1'b1;
      end
      StBeq: begin
        alu_src_a = SRC_A_RD1;
        alu_op    = AluOpSub;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef RISCV_CTRL_BNE_EN
  assign branch_cond = (funct3 == 3'b001) ? ~zero : zero;
`else
  assign branch_cond = zero;
`endif

  assign pc_write = pc_update | (branch & branch_cond);

  always_comb begin
    imm_src = IMM_I;
    unique case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

  riscv_alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .op5_i         (op[5]),
    .funct7b5_i    (funct7b5),
    .alu_control_o (alu_sel)
  );

  assign alu_control = ALU_SEL_W'(alu_sel);

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Directed bench for riscv_mc_controller; expected output vectors are written
// out by hand per state and instruction. Honours RISCV_CTRL_BNE_EN.
module tb_riscv_mc_controller;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [15:0] obs;

  int tests = 0;
  int fails = 0;

`ifdef RISCV_CTRL_BNE_EN
  localparam logic BNE_ON_ZERO0 = 1'b1;
`else
  localparam logic BNE_ON_ZERO0 = 1'b0;
`endif

  riscv_mc_controller #(.ALU_SEL_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .alu_control (alu_control)
  );

  assign obs = {pc_write, adr_src, mem_write, ir_write, reg_write,
                result_src, alu_src_a, alu_src_b, imm_src, alu_control};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic pc, input logic adr, input logic mw,
                                     input logic ir, input logic rw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] imm, input logic [2:0] alu);
    return {pc, adr, mw, ir, rw, rs, sa, sb, imm, alu};
  endfunction

  task automatic chk(input string tag, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    op       = 7'b0000011;
    funct3   = 3'b000;
    funct7b5 = 1'b0;
    zero     = 1'b0;
    #3;
    chk("reset_fetch", mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));
    @(negedge clk);
    reset = 1'b0;

    // lw: 5 cycles
    chk("lw_fetch",   mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));
    tick(); chk("lw_decode",  mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000));
    tick(); chk("lw_memadr",  mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000));
    tick(); chk("lw_memread", mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
    tick(); chk("lw_memwb",   mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000));
    tick(); chk("lw_refetch", mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));

    // reset asserted mid-MEMREAD
    tick(); tick(); tick();
    chk("rst_pre_memread", mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
    #2 reset = 1'b1;
    #1 chk("rst_async_fetch", mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));
    tick(); chk("rst_held_fetch", mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));
    @(negedge clk);
    reset = 1'b0;
    #1 chk("rst_release_fetch", mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));
    tick(); chk("rst_then_decode", mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000));
    tick(); tick(); tick();
    chk("rst_lw_memwb", mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000));
    tick();

    // sw: 4 cycles
    op = 7'b0100011;
    #1 chk("sw_fetch", mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000));
    tick(); chk("sw_decode",   mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000));
    tick(); chk("sw_memadr",   mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000));
    tick(); chk("sw_memwrite", mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000));
    tick(); chk("sw_refetch",  mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000));

    // R-type sub
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    tick(); chk("rsub_decode", mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000));
    tick(); chk("rsub_exec",   mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001));
    tick(); chk("rsub_aluwb",  mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
    tick(); chk("rsub_fetch",  mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));

    // I-type with the same fields: addi, never sub
    op = 7'b0010011;
    tick(); tick();
    chk("iadd_exec", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000));
    funct3 = 3'b110;
    #1 chk("iori_exec", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b011));
    funct3 = 3'b111;
    #1 chk("iandi_exec", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b010));
    funct3 = 3'b100;
    #1 chk("ixori_exec", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000));
    tick(); chk("i_aluwb", mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
    tick();

    // R-type slt, then add with funct7b5=0
    op = 7'b0110011; funct3 = 3'b010; funct7b5 = 1'b0;
    tick(); tick();
    chk("rslt_exec", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b100));
    funct3 = 3'b000;
    #1 chk("radd_exec", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000));
    tick(); tick();

    // jal
    op = 7'b1101111; funct3 = 3'b000;
    #1 chk("jal_fetch", mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b11, 3'b000));
    tick(); chk("jal_decode", mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b11, 3'b000));
    tick(); chk("jal_state",  mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000));
    tick(); chk("jal_aluwb",  mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000));
    tick(); chk("jal_refetch", mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b11, 3'b000));

    // beq: zero only matters in the BEQ state
    op = 7'b1100011;
    tick();
    zero = 1'b1;
    #1 chk("beq_decode_zero", mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000));
    tick(); chk("beq_taken",  mk(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001));
    zero = 1'b0;
    #1 chk("beq_not_taken", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001));
    tick(); chk("beq_refetch", mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000));

    // bne encoding: behaviour depends on the build
    funct3 = 3'b001;
    tick(); tick();
    chk("bne_zero0", mk(BNE_ON_ZERO0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001));
    zero = 1'b1;
    #1 chk("bne_zero1", mk(~BNE_ON_ZERO0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001));
    tick();
    zero = 1'b0; funct3 = 3'b000;

    // unknown op: 2-cycle nop
    op = 7'b0000000;
    #1 chk("nop_fetch", mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));
    tick(); chk("nop_decode",  mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000));
    tick(); chk("nop_refetch", mk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
